// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: register-index constants shared by the write-register mux and the register bank.
// Contents: zero/sp/ra indices, stack-top reset value, index type, write-register mux select encoding.
package reg_bank_pkg;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t    REG_ZERO         = 5'd0;
    localparam reg_idx_t    REG_SP           = 5'd29;
    localparam reg_idx_t    REG_RA           = 5'd31;
    localparam logic [31:0] SP_RESET_DEFAULT = 32'd227;

    typedef enum logic [1:0] {
        WR_SEL_RD = 2'b00,
        WR_SEL_RT = 2'b01,
        WR_SEL_RA = 2'b10,
        WR_SEL_SP = 2'b11
    } wr_sel_e;

    function automatic reg_idx_t wr_reg_sel(input wr_sel_e sel, input reg_idx_t rd, input reg_idx_t rt);
        return (sel == WR_SEL_RD) ? rd :
               (sel == WR_SEL_RT) ? rt :
               (sel == WR_SEL_RA) ? REG_RA : REG_SP;
    endfunction

endpackage

// File: rtl/reg_bank_read_port.sv
// reg_read_port: one read port of the register bank -- zero check, write bypass, optional output register.
// Ports: clk/reset (async active-high), addr_i read index, arr_i array contents at addr_i,
//        wr_en_i/wr_addr_i/wr_data_i current write request, rd_data_o read data.
module reg_read_port
    import reg_bank_pkg::*;
#(
    parameter bit READ_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  reg_idx_t    addr_i,
    input  logic [31:0] arr_i,
    input  logic        wr_en_i,
    input  reg_idx_t    wr_addr_i,
    input  logic [31:0] wr_data_i,
    output logic [31:0] rd_data_o
);

    logic [31:0] data_d;

    // A write to index 0 can never be forwarded since index 0 is checked first.
    assign data_d = (addr_i == REG_ZERO) ? 32'd0 :
                    (BYPASS && wr_en_i && wr_addr_i == addr_i) ? wr_data_i : arr_i;

    generate
        if (READ_REG) begin : g_reg
            logic [31:0] data_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) data_q <= 32'd0;
                else       data_q <= data_d;
            end
            assign rd_data_o = data_q;
        end else begin : g_comb
            assign rd_data_o = data_d;
        end
    endgenerate

endmodule

// File: rtl/reg_bank.sv
// reg_bank: 32 x 32-bit MIPS general-purpose register file, register 0 hardwired to zero, $sp reset to stack top.
// Ports: clk, reset (async active-high), RegWrite/WriteReg/WriteData write request,
//        ReadReg1/ReadReg2 -> ReadData1/ReadData2 operands, sp_out live contents of register 29.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter logic [31:0] SP_RESET = SP_RESET_DEFAULT,
    parameter bit          READ_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite,
    input  reg_idx_t    WriteReg,
    input  logic [31:0] WriteData,
    input  reg_idx_t    ReadReg1,
    input  reg_idx_t    ReadReg2,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2,
    output logic [31:0] sp_out
);

    // Entry 0 is not stored; the read ports substitute zero for it.
    logic [31:0] regs_q [1:31];
    logic [31:0] regs_d [1:31];
    logic [31:0] arr1, arr2;

    always_comb begin
        regs_d = regs_q;
        if (RegWrite && WriteReg != REG_ZERO) regs_d[WriteReg] = WriteData;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k < 32; k++) regs_q[k] <= (k == int'(REG_SP)) ? SP_RESET : 32'd0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign arr1   = (ReadReg1 == REG_ZERO) ? 32'd0 : regs_q[ReadReg1];
    assign arr2   = (ReadReg2 == REG_ZERO) ? 32'd0 : regs_q[ReadReg2];
    assign sp_out = regs_q[REG_SP];

    reg_read_port #(.READ_REG(READ_REG), .BYPASS(BYPASS)) u_port1 (
        .clk(clk), .reset(reset), .addr_i(ReadReg1), .arr_i(arr1),
        .wr_en_i(RegWrite), .wr_addr_i(WriteReg), .wr_data_i(WriteData), .rd_data_o(ReadData1)
    );

    reg_read_port #(.READ_REG(READ_REG), .BYPASS(BYPASS)) u_port2 (
        .clk(clk), .reset(reset), .addr_i(ReadReg2), .arr_i(arr2),
        .wr_en_i(RegWrite), .wr_addr_i(WriteReg), .wr_data_i(WriteData), .rd_data_o(ReadData2)
    );

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed checks of a registered/bypassed bank and a combinational/no-bypass bank sharing inputs.
module tb_reg_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteReg, ReadReg1, ReadReg2;
    logic [31:0] WriteData;
    logic [31:0] rd1, rd2, sp;
    logic [31:0] c_rd1, c_rd2, c_sp;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_bank dut (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(rd1), .ReadData2(rd2), .sp_out(sp)
    );

    reg_bank #(.READ_REG(1'b0), .BYPASS(1'b0)) dut_c (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(c_rd1), .ReadData2(c_rd2), .sp_out(c_sp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic after_pos();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; RegWrite = 1'b0; WriteReg = 5'd0; WriteData = 32'd0;
        ReadReg1 = 5'd29; ReadReg2 = 5'd5;
        #1 reset = 1'b1;
        #1;
        check("rst_rd1_reg", rd1, 32'd0);
        check("rst_rd2_reg", rd2, 32'd0);
        check("rst_sp", sp, 32'd227);
        check("rst_c_rd1", c_rd1, 32'd227);
        check("rst_c_rd2", c_rd2, 32'd0);
        after_pos();
        check("rst_hold_rd1", rd1, 32'd0);
        @(negedge clk) reset = 1'b0;
        after_pos();
        check("read29_reg", rd1, 32'd227);
        check("read5_reg", rd2, 32'd0);

        // write 0xDEADBEEF to 8 while reading other indices
        @(negedge clk);
        RegWrite = 1'b1; WriteReg = 5'd8; WriteData = 32'hDEADBEEF; ReadReg1 = 5'd1; ReadReg2 = 5'd1;
        after_pos();
        @(negedge clk);
        RegWrite = 1'b0; ReadReg1 = 5'd8; ReadReg2 = 5'd8;
        #1;
        check("w8_c_rd1", c_rd1, 32'hDEADBEEF);
        check("w8_c_rd2", c_rd2, 32'hDEADBEEF);
        check("w8_reg_lat", rd1, 32'd0);
        after_pos();
        check("w8_rd1", rd1, 32'hDEADBEEF);
        check("w8_rd2", rd2, 32'hDEADBEEF);

        // write to index 0 is discarded
        @(negedge clk);
        RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h12345678; ReadReg1 = 5'd0; ReadReg2 = 5'd8;
        #1;
        check("w0_c_byp", c_rd1, 32'd0);
        after_pos();
        check("w0_rd1", rd1, 32'd0);
        check("w0_rd2", rd2, 32'hDEADBEEF);
        @(negedge clk) RegWrite = 1'b0;
        #1;
        check("w0_c_rd1", c_rd1, 32'd0);
        check("w0_c_rd2", c_rd2, 32'hDEADBEEF);

        // same-cycle write/read of index 31
        @(negedge clk);
        RegWrite = 1'b1; WriteReg = 5'd31; WriteData = 32'h55; ReadReg1 = 5'd31; ReadReg2 = 5'd31;
        #1;
        check("byp_c_old", c_rd1, 32'd0);
        after_pos();
        check("byp_rd1", rd1, 32'h55);
        check("byp_rd2", rd2, 32'h55);
        check("byp_c_next", c_rd1, 32'h55);

        // RegWrite=0 leaves entries unchanged
        @(negedge clk);
        RegWrite = 1'b0; WriteReg = 5'd3; WriteData = 32'hFFFF; ReadReg1 = 5'd3; ReadReg2 = 5'd31;
        after_pos();
        after_pos();
        check("nowr_rd1", rd1, 32'd0);
        check("nowr_c_rd1", c_rd1, 32'd0);
        check("nowr_rd2", rd2, 32'h55);

        // write $sp then async reset between edges
        @(negedge clk);
        RegWrite = 1'b1; WriteReg = 5'd29; WriteData = 32'hAA; ReadReg1 = 5'd29; ReadReg2 = 5'd8;
        after_pos();
        check("sp_wr", sp, 32'hAA);
        check("sp_wr_c", c_sp, 32'hAA);
        check("sp_rd1", rd1, 32'hAA);
        @(negedge clk) RegWrite = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("arst_sp", sp, 32'd227);
        check("arst_c_rd1", c_rd1, 32'd227);
        check("arst_rd1", rd1, 32'd0);
        check("arst_c_rd2", c_rd2, 32'd0);

        // write during reset is lost; first write after release is taken
        RegWrite = 1'b1; WriteReg = 5'd8; WriteData = 32'h1;
        after_pos();
        check("rstwr_lost", c_rd2, 32'd0);
        @(negedge clk);
        reset = 1'b0; WriteData = 32'h77;
        #1;
        check("pre_first_wr", c_rd2, 32'd0);
        after_pos();
        check("first_wr", c_rd2, 32'h77);
        check("first_wr_byp", rd2, 32'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bank.md
# reg_bank

General-purpose register file of the multicycle MIPS datapath, directly downstream of the write-register select mux. It holds 32 × 32-bit registers, takes the 5-bit destination index produced by that mux (`rd`/`rt`/31/29) plus write data and enable from the control unit, and supplies the `rs`/`rt` operands to the A/B operand latches. Register 0 reads as zero. Register 29 (`$sp`) resets to the stack top.

## Interface
- `SP_RESET`, default 227: reset value of register 29.
- `READ_REG`, default 1: 1 = registered read data (one-cycle latency); 0 = combinational read.
- `BYPASS`, default 1: 1 = a same-cycle write to the addressed register is forwarded to the read path.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `RegWrite`  in  1  write enable from the control unit.
- `WriteReg`  in  5  destination index, driven from the write-register mux output.
- `WriteData`  in  32  data to write.
- `ReadReg1`  in  5  `rs` index (instruction [25:21]).
- `ReadReg2`  in  5  `rt` index (instruction [20:16]).
- `ReadData1`  out  32  value of `ReadReg1`.
- `ReadData2`  out  32  value of `ReadReg2`.
- `sp_out`  out  32  current contents of register 29, combinational from the array, for debug and trace.

## Operation
- Storage: 32 entries × 32 bits, entry 0 not stored (constant zero).
- Write: on a rising `clk` with `RegWrite`=1 and `WriteReg`≠0, `regs[WriteReg]` ← `WriteData`.
  - A write to index 0 is silently discarded; no error.
  - `RegWrite`=0 leaves all entries unchanged regardless of the other inputs.
- Read value for index `i`:
  - `i`=0 → 0.
  - Otherwise, if `BYPASS`=1, `RegWrite`=1 and `WriteReg`=`i` → `WriteData`.
  - Otherwise → `regs[i]`.
- `READ_REG`=1: `ReadData1`/`ReadData2` are registered every cycle (no enable) from the read value above.
- `READ_REG`=0: `ReadData1`/`ReadData2` equal the read value combinationally.
- Both read ports addressing the same index return identical data.
- Reset (async, any time, including mid-write):
  - `regs[29]` ← `SP_RESET`; every other entry ← 0.
  - Registered read outputs ← 0.
  - `sp_out` follows the array and therefore shows `SP_RESET`.
  - A write presented in the same cycle that reset is asserted is lost.
- No state machine. Behaviour is entirely array update plus optional output register.

## Timing
- Write latency: data written at edge N is visible in the array after edge N.
  - Without bypass, a combinational read sees the new data in cycle N+1.
  - With `READ_REG`=1, the registered output shows it after edge N+1.
- Bypass with `READ_REG`=1: a read registered at edge N with a simultaneous write to the same index captures the new `WriteData`. This matches the control unit's "write-back and decode in the same cycle" case.
- Bypass with `READ_REG`=0: the output changes in the same cycle as the write inputs. This is a combinational path from `WriteData` to `ReadData*`.
- Reset deassertion: the first write is accepted on the first rising edge with `reset`=0.

## Structure
- Shared CPU package holds:
  - `REG_ZERO`=0, `REG_SP`=29, `REG_RA`=31.
  - `SP_RESET_DEFAULT`=227.
  - The 5-bit register-index type.
  - The write-register mux selects 00=`rd`, 01=`rt`, 10=31, 11=29, so the mux and the register bank agree on constants.
- A single sub-module `reg_read_port` is natural. It implements zero-check, bypass compare and the optional output register, and is instantiated twice.

## Test plan
- Reset, then read 29 and 5 → `ReadData`=227 and 0; `sp_out`=227; registered outputs are 0 while `reset`=1.
- Write 0xDEADBEEF to index 8, then read index 8 on both ports → both return 0xDEADBEEF. With `READ_REG`=1 the data appears one cycle after the read address is applied.
- Write 0x12345678 to index 0, then read index 0 → 0; no other entry changes.
- `BYPASS`=1: same-cycle write of 0x55 to index 31 while `ReadReg1`=31 → `ReadData1`=0x55. With `BYPASS`=0 the old value is returned that cycle and 0x55 the next.
- `RegWrite`=0 with `WriteReg`=3 and `WriteData`=0xFFFF → index 3 is still 0.
- Write 0xAA to index 29, then assert `reset` asynchronously between edges → `sp_out` returns to 227 immediately, without waiting for a clock edge.
